// File: rtl/riscv_mmio_pkg.sv
// riscv_mmio_pkg: register offsets, STATUS bit positions and UART FSM states
package riscv_mmio_pkg;
  localparam logic [31:0] TXDATA_OFF = 32'h0;
  localparam logic [31:0] STATUS_OFF = 32'h4;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: power-of-two circular FIFO with combinational read data
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rptr];
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= do_push ? wptr + 1'b1 : wptr;
      rptr <= do_pop ? rptr + 1'b1 : rptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter fed by a byte FIFO
module mmio_uart_tx
  import riscv_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  state_t state, state_n;
  logic [BW-1:0] cnt;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] data, data_n, dout;
  logic full, empty, pop, overflow, done, sel_tx, sel_st, unused_wdata;
  assign sel_tx = addr == BASE_ADDR + TXDATA_OFF;
  assign sel_st = addr == BASE_ADDR + STATUS_OFF;
  assign done = cnt == BW'(CLKS_PER_BIT - 1);
  assign busy = state != IDLE || !empty;
  assign unused_wdata = ^wdata[31:8];
  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .reset(reset), .push(we && sel_tx), .pop(pop),
    .din(wdata[7:0]), .dout(dout), .full(full), .empty(empty)
  );
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
      START: state_n = done ? DATA : START;
      DATA: state_n = (done && bit_idx == 3'd7) ? STOP : DATA;
      STOP: begin
        pop = done && !empty;
        state_n = !done ? STOP : empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
    bit_n = (state_n != state) ? 3'd0 : (state == DATA && done) ? bit_idx + 3'd1 : bit_idx;
    data_n = pop ? dout : data;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      data <= '0;
      tx <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || done || state_n == IDLE) ? '0 : cnt + 1'b1;
      bit_idx <= bit_n;
      data <= data_n;
      tx <= state_n == START ? 1'b0 : state_n == DATA ? data_n[bit_n] : 1'b1;
      overflow <= (we && sel_st) ? 1'b0 : (we && sel_tx && full && !pop) ? 1'b1 : overflow;
    end
  always_comb begin
    rdata = '0;
    if (sel_st) begin
      rdata[ST_FULL] = full;
      rdata[ST_EMPTY] = empty;
      rdata[ST_ACTIVE] = state != IDLE;
      rdata[ST_OVF] = overflow;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench decoding the serial line against queued bytes
module tb_mmio_uart_tx;
  localparam int CPB = 16;
  logic clk = 1'b0, reset = 1'b1, we = 1'b0, tx, busy;
  logic [31:0] addr = 32'h0, wdata = 32'h0, rdata, st;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .BASE_ADDR(32'h100)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx(tx), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
    addr = 32'h0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask
  task automatic push_byte(input logic [7:0] b);
    wr(32'h100, {$urandom} & 32'hFFFF_FF00 | 32'(b));
    exp_q.push_back(b);
  endtask
  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 3000), 32'd1);
  endtask
  // monitor: UART receiver sampling mid-bit, compared against the expected queue
  initial begin
    logic prev = 1'b1, ab;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!reset && prev === 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        ab = 1'b0;
        repeat (CPB / 2) begin @(negedge clk); ab |= reset; end
        if (!ab) chk("start_bit", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); ab |= reset; end
          b[i] = tx;
        end
        repeat (CPB) begin @(negedge clk); ab |= reset; end
        if (!ab) begin
          chk("stop_bit", 32'(tx), 32'd1);
          if (exp_q.size() == 0) chk("unexpected_frame", 32'(b), 32'hFFFF_FFFF);
          else chk("frame_byte", 32'(b), 32'(exp_q.pop_front()));
        end
      end
      prev = tx;
    end
  end
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
  initial begin
    int s0, n;
    repeat (3) @(negedge clk);
    we = 1'b1; addr = 32'h100; wdata = 32'h55;
    @(negedge clk);
    we = 1'b0;
    reset = 1'b0;
    rd(32'h104, st); chk("reset_status", st, 32'h2);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tx", 32'(tx), 32'd1);
    // single frame latency and timing
    push_byte(8'hA5);
    chk("lat_c1_tx", 32'(tx), 32'd1);
    chk("busy_after_write", 32'(busy), 32'd1);
    @(negedge clk); chk("lat_c2_tx", 32'(tx), 32'd0);
    repeat (15) @(negedge clk); chk("start_last", 32'(tx), 32'd0);
    @(negedge clk); chk("bit0_first", 32'(tx), 32'd1);
    repeat (143) @(negedge clk); chk("stop_last_tx", 32'(tx), 32'd1);
    chk("stop_last_busy", 32'(busy), 32'd1);
    @(negedge clk); chk("busy_drop", 32'(busy), 32'd0);
    wait_drain("drain_single");
    // five back-to-back bytes while idle
    starts.delete();
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    rd(32'h104, st); chk("b2b_no_ovf", 32'(st[3]), 32'd0);
    wait_drain("drain_b2b");
    chk("b2b_frames", starts.size(), 5);
    for (int i = 1; i < 5 && i < starts.size(); i++) chk("b2b_spacing", starts[i] - starts[i-1], 160);
    // overflow while a frame is in flight
    push_byte(8'h3C);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b = 8'($urandom);
      wr(32'h100, 32'(b));
      if (i < 4) exp_q.push_back(b);
    end
    rd(32'h104, st); chk("ovf_status", st, 32'hD);
    wr(32'h104, $urandom);
    rd(32'h104, st); chk("ovf_clear", st, 32'h5);
    wait_drain("drain_ovf");
    // push coincident with the STOP-end pop while full
    starts.delete();
    push_byte(8'h11);
    for (int i = 0; i < 4; i++) push_byte(8'(8'h20 + i));
    n = 0;
    while (starts.size() == 0 && n < 100) begin @(negedge clk); n++; end
    chk("coinc_start_seen", 32'(starts.size() > 0), 32'd1);
    s0 = starts.size() > 0 ? starts[0] : cyc;
    while (cyc < s0 + 158) @(negedge clk);
    rd(32'h104, st); chk("coinc_full_before", st, 32'h5);
    push_byte(8'h77);
    rd(32'h104, st); chk("coinc_status_after", st, 32'h5);
    wait_drain("drain_coinc");
    // reset in the middle of a DATA bit discards the frame and the queue
    push_byte(8'h96);
    push_byte(8'h69);
    repeat (16 + 16 * 3 + 6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    chk("rst_mid_tx", 32'(tx), 32'd1);
    rd(32'h104, st); chk("rst_mid_status", st, 32'h2);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    n = starts.size();
    repeat (400) @(negedge clk);
    chk("rst_no_frame", starts.size(), n);
    // unmapped addresses
    rd(32'h108, st); chk("rd_108", st, 32'h0);
    rd(32'h100, st); chk("rd_txdata", st, 32'h0);
    wr(32'h10C, 32'hFFFF_FFFF);
    rd(32'h104, st); chk("wr_10c_status", st, 32'h2);
    chk("wr_10c_busy", 32'(busy), 32'd0);
    // randomized traffic, pushes only when the FIFO has room
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      n = 0;
      rd(32'h104, st);
      while (st[0] && n < 2000) begin @(negedge clk); rd(32'h104, st); n++; end
      chk("rand_room", 32'(n < 2000), 32'd1);
      push_byte(8'($urandom));
    end
    wait_drain("drain_rand");
    rd(32'h104, st); chk("final_status", st, 32'h2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
